// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the shift-and-add multiplier: the
//               2-bit controller state type and its encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int c_STATE_W = 2;

    // Controller states. All four codes of the 2-bit register are used.
    typedef enum logic [c_STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mult_datapath
// Description : Datapath of the shift-and-add multiplier. Holds the shifted
//               multiplicand, the remaining multiplier bits, the running
//               partial product, the sign flag and the registered result.
// Ports       : clk, rst_n       - clock, async active-low reset
//               load             - capture operand magnitudes, clear prod
//               iterate          - one add/shift step
//               fix              - apply sign and register the result
//               a, b, is_signed  - operands and signedness
//               cnt              - iteration counter from the controller
//               product          - registered 2*WIDTH-bit result
//               cnt_last         - cnt is on the final iteration
//               b_rem_zero       - no set bits left above b_reg[0]
// Revision    : 1.0 - initial release
// ============================================================================
module mult_datapath #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 iterate,
    input  logic                 fix,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic [CNT_W-1:0]     cnt,
    output logic [2*WIDTH-1:0]   product,
    output logic                 cnt_last,
    output logic                 b_rem_zero
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_neg;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    // Magnitudes: -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct
    // unsigned magnitude, so no extra bit is needed.
    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    assign cnt_last   = (cnt == c_CNT_LAST);
    // Looks at what b_reg will hold after the current shift.
    assign b_rem_zero = (r_b[WIDTH-1:1] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_prod  <= '0;
            r_neg   <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                r_a    <= {{WIDTH{1'b0}}, w_a_mag};
                r_b    <= w_b_mag;
                r_prod <= '0;
                r_neg  <= w_a_neg ^ w_b_neg;
            end else if (iterate) begin
                if (r_b[0]) begin
                    r_prod <= r_prod + r_a;
                end
                r_a <= r_a << 1;
                r_b <= r_b >> 1;
            end
            // Magnitude product never exceeds 2^(2*WIDTH-2), so the negation
            // cannot overflow the result width.
            if (fix) begin
                product <= r_neg ? -r_prod : r_prod;
            end
        end
    end

endmodule : mult_datapath
`default_nettype wire

// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential shift-and-add multiplier with valid_data/ack
//               handshake, unsigned or two's-complement per operation and
//               optional early termination on an exhausted multiplier.
// Ports       : Clock, Reset_n   - clock (rising edge), async active-low reset
//               valid_data       - operands valid (sampled in IDLE)
//               a, b             - multiplicand, multiplier
//               is_signed        - two's-complement operands
//               ack              - result consumed (sampled in DONE)
//               busy             - controller not in IDLE
//               Done_Flag        - result valid (registered)
//               product          - 2*WIDTH-bit result, held while Done_Flag
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 valid_data,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic                 ack,
    output logic                 busy,
    output logic                 Done_Flag,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_load;
    logic               w_iter;
    logic               w_fix;
    logic               w_cnt_last;
    logic               w_b_rem_zero;

    mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (c_CNT_W)
    ) u_datapath (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .load       (w_load),
        .iterate    (w_iter),
        .fix        (w_fix),
        .a          (a),
        .b          (b),
        .is_signed  (is_signed),
        .cnt        (r_cnt),
        .product    (product),
        .cnt_last   (w_cnt_last),
        .b_rem_zero (w_b_rem_zero)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_iter = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_data) begin
                    w_load = 1'b1;
                    w_next = CALC;
                end
            end
            CALC: begin
                w_iter = 1'b1;
                if (w_cnt_last || (EARLY_EXIT && w_b_rem_zero)) begin
                    w_next = SIGN;
                end
            end
            SIGN: begin
                w_fix  = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                if (ack) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Iteration counter and result-valid flag.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt     <= '0;
            Done_Flag <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_iter) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            case (r_state)
                SIGN:    Done_Flag <= 1'b1;
                DONE:    if (ack) Done_Flag <= 1'b0;
                IDLE,
                CALC:    Done_Flag <= Done_Flag;
                default: Done_Flag <= 1'b0;
            endcase
        end
    end

    assign busy = (r_state != IDLE);

endmodule : shift_add_mult
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Self-checking bench for shift_add_mult. Eight instances cover
//               WIDTH in {4,8,16,32} x EARLY_EXIT in {0,1}; instance k has
//               WIDTH = 4 << (k/2) and EARLY_EXIT = k%2. Results and
//               latencies are checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

    logic        clk;
    logic        rst_n;
    logic [7:0]  valid;
    logic [7:0]  sgn;
    logic [7:0]  ack;
    logic [7:0]  busy;
    logic [7:0]  done;
    logic [31:0] a_in     [8];
    logic [31:0] b_in     [8];
    logic [63:0] prod_out [8];

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 8; k++) begin : g_dut
        localparam int W = 4 << (k / 2);
        logic [2*W-1:0] w_prod;

        shift_add_mult #(
            .WIDTH      (W),
            .EARLY_EXIT (k % 2)
        ) u_dut (
            .Clock      (clk),
            .Reset_n    (rst_n),
            .valid_data (valid[k]),
            .a          (a_in[k][W-1:0]),
            .b          (b_in[k][W-1:0]),
            .is_signed  (sgn[k]),
            .ack        (ack[k]),
            .busy       (busy[k]),
            .Done_Flag  (done[k]),
            .product    (w_prod)
        );

        assign prod_out[k] = 64'(w_prod);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int width_of(input int k);
        return 4 << (k / 2);
    endfunction

    function automatic logic [31:0] op_mask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [63:0] prod_mask(input int w);
        return (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Reference: integer product of the operands interpreted per is_signed.
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] av,
                                             input logic [31:0] bv, input bit s);
        longint x, y;
        x = longint'(av);
        y = longint'(bv);
        if (s && av[w-1]) x = x - (longint'(1) << w);
        if (s && bv[w-1]) y = y - (longint'(1) << w);
        return 64'(x * y) & prod_mask(w);
    endfunction

    // Reference: number of multiplier iterations.
    function automatic int ref_iters(input int w, input bit ee, input logic [31:0] bv,
                                     input bit s);
        longint m;
        int     n;
        if (!ee) return w;
        m = longint'(bv);
        if (s && bv[w-1]) m = (longint'(1) << w) - m;
        n = 0;
        while (m > 0) begin
            m = m >> 1;
            n++;
        end
        return (n == 0) ? 1 : n;
    endfunction

    // Presents operands for one cycle; returns #1 after the capture edge.
    task automatic start_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                            input bit s);
        @(negedge clk);
        a_in[k]  = av;
        b_in[k]  = bv;
        sgn[k]   = s;
        valid[k] = 1'b1;
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
    endtask

    // Counts edges after capture until Done_Flag; checks busy along the way.
    task automatic wait_done(input int k, input int exp_lat);
        int lat;
        int busy_low;
        lat      = 0;
        busy_low = (busy[k] == 1'b1) ? 0 : 1;
        while (!done[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (!busy[k]) busy_low++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_during_op", 64'(busy_low), 64'd0);
    endtask

    task automatic do_ack(input int k, input int dly, input logic [63:0] exp_p);
        repeat (dly) @(posedge clk);
        #1;
        check("done_hold", 64'(done[k]), 64'd1);
        check("product_hold", prod_out[k], exp_p);
        ack[k] = 1'b1;
        @(posedge clk);
        #1;
        ack[k] = 1'b0;
        check("done_clear", 64'(done[k]), 64'd0);
        check("busy_clear", 64'(busy[k]), 64'd0);
        check("product_kept", prod_out[k], exp_p);
    endtask

    task automatic op(input int k, input logic [31:0] av, input logic [31:0] bv,
                      input bit s, input int dly, input logic [63:0] exp_p,
                      input int exp_lat);
        start_op(k, av, bv, s);
        wait_done(k, exp_lat);
        check("product", prod_out[k], exp_p);
        do_ack(k, dly, exp_p);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        valid = '0;
        sgn   = '0;
        ack   = '0;
        for (int k = 0; k < 8; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
        end

        #12;
        for (int k = 0; k < 8; k++) begin
            check("reset_busy", 64'(busy[k]), 64'd0);
            check("reset_done", 64'(done[k]), 64'd0);
            check("reset_product", prod_out[k], 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH 8, full iteration count
        op(2, 32'd13,  32'd11,  1'b0, 1, 64'h008F, 9);
        op(2, 32'hFD,  32'd5,   1'b1, 0, 64'hFFF1, 9);
        op(2, 32'h80,  32'h80,  1'b1, 2, 64'h4000, 9);
        op(2, 32'h80,  32'h7F,  1'b1, 0, 64'hC080, 9);
        op(2, 32'hFD,  32'd5,   1'b0, 3, 64'h04F1, 9);

        // WIDTH 8, early exit
        op(3, 32'd255, 32'd1,   1'b0, 0, 64'h00FF, 2);
        op(3, 32'd77,  32'd0,   1'b0, 0, 64'h0000, 2);
        op(3, 32'd3,   32'h80,  1'b0, 1, 64'h0180, 9);
        op(3, 32'd3,   32'hFF,  1'b1, 0, 64'hFFFD, 2);

        // Result held in DONE while inputs churn and ack stays low
        start_op(2, 32'd13, 32'd11, 1'b0);
        wait_done(2, 9);
        check("product", prod_out[2], 64'h008F);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            valid[2] = ~valid[2];
            a_in[2]  = $urandom;
            b_in[2]  = $urandom;
            sgn[2]   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("hold_done", 64'(done[2]), 64'd1);
            check("hold_product", prod_out[2], 64'h008F);
        end
        // ack and valid_data together: ack wins, no new operation starts
        @(negedge clk);
        ack[2]   = 1'b1;
        valid[2] = 1'b1;
        @(posedge clk);
        #1;
        ack[2]   = 1'b0;
        valid[2] = 1'b0;
        check("ack_done_clear", 64'(done[2]), 64'd0);
        check("ack_busy_clear", 64'(busy[2]), 64'd0);
        @(posedge clk);
        #1;
        check("idle_after_ack", 64'(busy[2]), 64'd0);
        op(2, 32'd7, 32'd9, 1'b0, 0, 64'h003F, 9);
        op(2, 32'd2, 32'd2, 1'b0, 0, 64'h0004, 9);

        // Asynchronous reset mid-calculation
        start_op(2, 32'd200, 32'd255, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy[2]), 64'd0);
        check("abort_done", 64'(done[2]), 64'd0);
        check("abort_product", prod_out[2], 64'd0);
        rst_n = 1'b1;
        op(2, 32'd6, 32'd7, 1'b0, 1, 64'h002A, 9);

        // Random regression on every width / early-exit combination
        for (int k = 0; k < 8; k++) begin
            int w;
            bit ee;
            w  = width_of(k);
            ee = bit'(k % 2);
            for (int i = 0; i < 25; i++) begin
                logic [31:0] av, bv;
                bit          s;
                av = $urandom & op_mask(w);
                bv = $urandom & op_mask(w);
                // Bias toward short multipliers so early exit gets exercised.
                if (i % 4 == 1) bv = bv >> $urandom_range(0, w - 1);
                if (i % 8 == 3) bv = 32'd0;
                s = 1'($urandom_range(0, 1));
                op(k, av, bv, s, $urandom_range(0, 10),
                   ref_prod(w, av, bv, s), ref_iters(w, ee, bv, s) + 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_shift_add_mult
`default_nettype wire

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-and-add multiplier: controller FSM and datapath in one block, with a valid_data/ack handshake.
- Multiplies two WIDTH-bit operands, unsigned or two's-complement, selected per operation.
- Optionally terminates early once the remaining multiplier bits are zero.
- Holds the 2·WIDTH-bit result until the consumer acknowledges it.

## Interface
- WIDTH, 32, operand width in bits (≥ 2).
- EARLY_EXIT, 1, 1 = stop iterating when remaining multiplier is zero; 0 = always WIDTH iterations.
- Clock  in  1  sole clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- valid_data  in  1  operands valid; sampled only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands; sampled with valid_data.
- ack  in  1  consumer has read result; sampled only in DONE.
- busy  out  1  state ≠ IDLE.
- Done_Flag  out  1  result valid; registered.
- product  out  2·WIDTH  result; registered, stable while Done_Flag = 1.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE, valid_data = 1 at edge:
  - a_reg ← |a| zero-extended to 2·WIDTH.
  - b_reg ← |b|; magnitudes are taken only if is_signed, else raw.
  - neg ← is_signed & (a[MSB] ^ b[MSB]).
  - prod ← 0, cnt ← 0, go to CALC.
- CALC, one iteration per cycle:
  - If b_reg[0], prod ← prod + a_reg.
  - Then a_reg ← a_reg << 1, b_reg ← b_reg >> 1, cnt ← cnt + 1.
  - Go to SIGN when cnt = WIDTH−1, or when EARLY_EXIT = 1 and (b_reg >> 1) = 0.
  - Iteration count N: EARLY_EXIT = 0 gives WIDTH. EARLY_EXIT = 1 gives max(1, bit position of MSB set in |b| + 1), so b = 0 gives N = 1.
- SIGN (one cycle): product ← neg ? −prod : prod (2·WIDTH-bit two's complement); Done_Flag ← 1; go to DONE.
- DONE: product and Done_Flag hold. ack = 1 at edge → Done_Flag ← 0, go to IDLE.
- valid_data outside IDLE is ignored; operand changes outside IDLE have no effect.
- Width rules:
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits.
  - Magnitude product ≤ 2^(2·WIDTH−2), so negation never overflows 2·WIDTH.
  - Unsigned result is exact.
- cnt width: $clog2(WIDTH).
- Unused state encoding → IDLE on next edge, Done_Flag ← 0.

## Timing
- Reset values: busy 0, Done_Flag 0, product 0, state IDLE, all internal registers 0. Reset_n low clears immediately, independent of Clock, in any state including mid-CALC.
- Latency: capture edge E0. CALC occupies edges E1..EN; SIGN completes at E(N+1). Done_Flag and product are valid after edge E(N+1).
  - EARLY_EXIT = 0: WIDTH+1 edges after E0.
- busy rises after E0 and falls after the ack edge.
- ack and valid_data high in the same cycle while in DONE: ack is honoured, valid_data ignored. A new operation needs valid_data in a later IDLE cycle, so minimum issue interval is N+3 cycles.
- ack held high continuously: DONE lasts exactly one cycle.
- product is not cleared on leaving DONE; it changes only at the next SIGN.

## Structure
- Shared package mult_pkg:
  - State encoding constants: IDLE = 2'd0, CALC = 2'd1, SIGN = 2'd2, DONE = 2'd3.
  - A state type for the 2-bit state register.
- One sub-module, mult_datapath, containing:
  - a_reg, b_reg, prod and neg registers;
  - the adder, shifts, abs/negate logic;
  - terminal-condition outputs (cnt_last, b_rem_zero).
- Top level holds the FSM and cnt and drives the load/iterate/fix enables.

## Test plan
- WIDTH = 8, EARLY_EXIT = 0, unsigned, a = 13, b = 11 → product 0x008F; Done_Flag rises exactly 9 edges after capture; busy high throughout.
- WIDTH = 8, signed cases:
  - a = −3 (0xFD), b = 5 → 0xFFF1.
  - a = −128, b = −128 → 0x4000.
  - a = −128, b = 127 → 0xC080.
  - Same operands with is_signed = 0, a = 0xFD, b = 5 → 0x04F1.
- WIDTH = 8, EARLY_EXIT = 1:
  - a = 255, b = 1 → 0x00FF after 2 edges.
  - b = 0 → 0x0000 after 2 edges.
  - b = 0x80 → 9 edges.
- DONE hold: ack = 0 for 20 cycles with valid_data toggling and operands changing → product and Done_Flag stable. ack pulse → Done_Flag low next edge; then back-to-back operations 7 × 9 = 0x003F and 2 × 2 = 0x0004 both correct.
- Reset_n low for 1 ns mid-CALC, between edges → busy, Done_Flag and product 0 before the next edge. After release, a = 6, b = 7 → 0x002A, with no residue from the aborted operation.
- Random regression, WIDTH ∈ {4, 8, 16, 32}, both modes, both EARLY_EXIT settings, random ack delay 0–10 → product matches reference model; latency matches the N formula.
